// File: rtl/seq_divider_if.sv
// Start/ready handshake bundle shared by the sequential divider and its requester.
interface seq_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             ready;
    logic             done;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, div_by_zero, ready, done
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, div_by_zero, ready, done
    );
endinterface

// File: rtl/seq_divider.sv
// Restoring divider producing one quotient bit per SHIFT/SUBTRACT pair, MSB first.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        SUBTRACT = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   a;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    // Trial subtraction at WIDTH+1 bits; the restoring step just keeps A when it does not fit.
    logic             fits;
    logic [WIDTH:0]   a_diff;
    logic [WIDTH:0]   a_next;
    logic [WIDTH-1:0] q_next;

    assign fits   = (a >= {1'b0, m});
    assign a_diff = a - {1'b0, m};
    assign a_next = fits ? a_diff : a;
    assign q_next = {q[WIDTH-1:1], fits};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            a           <= '0;
            q           <= '0;
            m           <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.divisor != '0) begin
                            a     <= '0;
                            q     <= bus.dividend;
                            m     <= bus.divisor;
                            count <= '0;
                            state <= SHIFT;
                        end else begin
                            quotient    <= '1;
                            remainder   <= bus.dividend;
                            div_by_zero <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    {a, q} <= {a[WIDTH-1:0], q, 1'b0};
                    state  <= SUBTRACT;
                end
                SUBTRACT: begin
                    a     <= a_next;
                    q     <= q_next;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        quotient    <= q_next;
                        remainder   <= a_next[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                        state       <= DONE;
                    end else begin
                        state <= SHIFT;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready       = (state == IDLE);
    assign bus.done        = (state == DONE);
    assign bus.quotient    = quotient;
    assign bus.remainder   = remainder;
    assign bus.div_by_zero = div_by_zero;
endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector and random check of seq_divider at WIDTH=8 against an arithmetic model.
module tb_seq_divider;
    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    seq_divider_if #(.WIDTH(8)) bus ();

    seq_divider #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] dvd;
        logic [7:0] dvs;
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        int         lat;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one division on the current ready cycle and follows it until ready returns.
    task automatic applyStimulus(input logic [7:0] dvd, input logic [7:0] dvs,
                                 input bit hold, input logic [7:0] alt_dvd,
                                 input logic [7:0] alt_dvs, input logic [7:0] exp_q,
                                 input logic [7:0] exp_r, input logic exp_dbz,
                                 input int exp_lat);
        int lat;
        int busy_ready;
        checkOutput("ready_before_start", int'(bus.ready), 1);
        bus.start    = 1'b1;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        step();
        if (!hold) bus.start = 1'b0;
        bus.dividend = alt_dvd;
        bus.divisor  = alt_dvs;
        lat        = 0;
        busy_ready = 0;
        for (int c = 1; c <= 40; c++) begin
            if (bus.ready) busy_ready++;
            if (bus.done) begin
                lat = c;
                break;
            end
            step();
        end
        checkOutput("done_latency", lat, exp_lat);
        checkOutput("ready_low_while_busy", busy_ready, 0);
        checkOutput("quotient", int'(bus.quotient), int'(exp_q));
        checkOutput("remainder", int'(bus.remainder), int'(exp_r));
        checkOutput("div_by_zero", int'(bus.div_by_zero), int'(exp_dbz));
        step();
        checkOutput("ready_after_done", int'(bus.ready), 1);
        checkOutput("done_single_pulse", int'(bus.done), 0);
        checkOutput("quotient_held", int'(bus.quotient), int'(exp_q));
        checkOutput("remainder_held", int'(bus.remainder), int'(exp_r));
        bus.start = 1'b0;
    endtask

    initial begin
        logic [7:0] rd;
        logic [7:0] rs;
        compared   = 0;
        mismatched = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 17};
        vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 17};
        vecs[2] = '{8'd255, 8'd16,  8'd15,  8'd15,  1'b0, 17};
        vecs[3] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 17};
        vecs[4] = '{8'd200, 8'd0,   8'd255, 8'd200, 1'b1, 1};
        vecs[5] = '{8'd9,   8'd3,   8'd3,   8'd0,   1'b0, 17};
        vecs[6] = '{8'd0,   8'd255, 8'd0,   8'd0,   1'b0, 17};
        vecs[7] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 17};

        repeat (2) step();
        checkOutput("reset_ready", int'(bus.ready), 1);
        checkOutput("reset_done", int'(bus.done), 0);
        checkOutput("reset_quotient", int'(bus.quotient), 0);
        checkOutput("reset_remainder", int'(bus.remainder), 0);
        checkOutput("reset_dbz", int'(bus.div_by_zero), 0);
        rst = 1'b0;
        step();
        checkOutput("release_ready", int'(bus.ready), 1);
        checkOutput("release_done", int'(bus.done), 0);

        for (int i = 0; i < 8; i++)
            applyStimulus(vecs[i].dvd, vecs[i].dvs, 1'b0, vecs[i].dvd, vecs[i].dvs,
                          vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].lat);

        // Start held high and operands swapped right after acceptance.
        applyStimulus(8'd100, 8'd7, 1'b1, 8'd50, 8'd5, 8'd14, 8'd2, 1'b0, 17);

        // Reset lands in cycle 6 of a 100/7 division.
        bus.start    = 1'b1;
        bus.dividend = 8'd100;
        bus.divisor  = 8'd7;
        step();
        bus.start = 1'b0;
        repeat (5) step();
        checkOutput("busy_before_abort", int'(bus.ready), 0);
        rst = 1'b1;
        #1;
        checkOutput("abort_ready", int'(bus.ready), 1);
        checkOutput("abort_done", int'(bus.done), 0);
        checkOutput("abort_quotient", int'(bus.quotient), 0);
        checkOutput("abort_remainder", int'(bus.remainder), 0);
        checkOutput("abort_dbz", int'(bus.div_by_zero), 0);
        #1;
        rst = 1'b0;
        applyStimulus(8'd255, 8'd255, 1'b0, 8'd0, 8'd0, 8'd1, 8'd0, 1'b0, 17);

        for (int i = 0; i < 1500; i++) begin
            rd = 8'($urandom_range(0, 255));
            rs = 8'($urandom_range(0, 255));
            if (i % 50 == 0) rd = 8'd255;
            if (i % 50 == 1) rd = 8'd0;
            if (i % 50 == 2) rs = 8'd255;
            if (i % 50 == 3) rs = 8'd0;
            if (rs == 8'd0)
                applyStimulus(rd, rs, 1'b0, ~rd, rs, 8'd255, rd, 1'b1, 1);
            else
                applyStimulus(rd, rs, 1'b0, ~rd, ~rs, 8'(int'(rd) / int'(rs)),
                              8'(int'(rd) % int'(rs)), 1'b0, 17);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
